// File: rtl/issue_dispatch_unit_pkg.sv
// Shared issue-stage types and constants.
//   issue_state_t : issue slot occupancy state
//   fu_lane_t     : functional-unit lane encoding
//   issue_slot_t  : decoded instruction held in the issue slot
//   reg_onehot    : register index to one-hot scoreboard mask
package issue_dispatch_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned FU_W       = 3;
    localparam int unsigned NUM_FU_DEF = 5;
    localparam int unsigned NUM_WB_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } issue_state_t;

    typedef enum logic [FU_W-1:0] {
        FU_ARITH = 3'd0,
        FU_MULT  = 3'd1,
        FU_DIV   = 3'd2,
        FU_LSU   = 3'd3,
        FU_CSR   = 3'd4
    } fu_lane_t;

    // fu is kept as raw bits: encodings 5..7 must be representable so they can be trapped
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [1:0]       src_used;
        logic             wen;
        logic [FU_W-1:0]  fu;
        logic             serial;
        logic             halt;
        logic             illegal;
        logic [XLEN-1:0]  pc;
    } issue_slot_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// 32-entry register pending scoreboard.
//   wb_valid/wb_rd : writeback completions that clear pending bits
//   rs1/rs2/rd     : register fields of the instruction under test
//   src_used/wen   : which of those fields participate in the hazard check
//   set_en         : instruction dispatched and writes rd; marks rd pending
//   hazard_c       : RAW/WAW hazard against the effective pending set
//   empty_c        : effective pending set is empty
//   busy           : any pending bit set in the registered state
module issue_scoreboard
    import issue_dispatch_unit_pkg::*;
#(
    parameter int unsigned NUM_WB = NUM_WB_DEF
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [REG_W*NUM_WB-1:0] wb_rd,
    input  logic [REG_W-1:0]        rs1,
    input  logic [REG_W-1:0]        rs2,
    input  logic [REG_W-1:0]        rd,
    input  logic [1:0]              src_used,
    input  logic                    wen,
    input  logic                    set_en,
    output logic                    hazard_c,
    output logic                    empty_c,
    output logic                    busy
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] eff;

    // Same-cycle writebacks resolve hazards; a same-cycle set on the cleared rd wins.
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) begin
                clr_mask = clr_mask | reg_onehot(wb_rd[REG_W*k +: REG_W]);
            end
        end
        eff      = pend_q & ~clr_mask;
        set_mask = (set_en && (rd != '0)) ? reg_onehot(rd) : '0;
        pend_d   = eff | set_mask;
        pend_d[0] = 1'b0;
        hazard_c = (src_used[0] && eff[rs1]) ||
                   (src_used[1] && eff[rs2]) ||
                   (wen && eff[rd]);
        empty_c  = (eff == '0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign busy = |pend_q;

endmodule

// File: rtl/issue_dispatch_unit.sv
// Single-entry issue slot with hazard check and per-lane dispatch.
//   in_*            : decoded instruction from the control unit, in_valid/in_ready handshake
//   fu_valid/ready  : one-hot dispatch handshake (0 arith, 1 mult, 2 div, 3 lsu, 4 csr)
//   out_*           : register fields and PC of the slot, stable while fu_valid is held
//   wb_valid/wb_rd  : writeback completions clearing scoreboard bits
//   flush           : empties the slot; scoreboard keeps in-flight writes
//   exc_valid/pc    : one-cycle illegal-instruction report
//   halted          : a halt has retired; only reset leaves this state
//   sb_busy         : any register write outstanding
//   stall/issue_count : held-but-not-dispatched cycles and dispatched instructions
module issue_dispatch_unit
    import issue_dispatch_unit_pkg::*;
#(
    parameter int unsigned NUM_FU = NUM_FU_DEF,
    parameter int unsigned NUM_WB = NUM_WB_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_W-1:0]        in_rs1,
    input  logic [REG_W-1:0]        in_rs2,
    input  logic [REG_W-1:0]        in_rd,
    input  logic [1:0]              in_src_used,
    input  logic                    in_wen,
    input  logic [FU_W-1:0]         in_fu,
    input  logic                    in_serial,
    input  logic                    in_halt,
    input  logic                    in_illegal,
    input  logic [XLEN-1:0]         in_pc,
    output logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU-1:0]       fu_ready,
    output logic [REG_W-1:0]        out_rs1,
    output logic [REG_W-1:0]        out_rs2,
    output logic [REG_W-1:0]        out_rd,
    output logic [XLEN-1:0]         out_pc,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [REG_W*NUM_WB-1:0] wb_rd,
    input  logic                    flush,
    output logic                    exc_valid,
    output logic [XLEN-1:0]         exc_pc,
    output logic                    halted,
    output logic                    sb_busy,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        issue_count
);

    issue_state_t      state_q, state_d;
    issue_slot_t       slot_q, slot_d;
    issue_slot_t       in_slot;
    logic              exc_valid_q, exc_valid_d;
    logic [XLEN-1:0]   exc_pc_q, exc_pc_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  issue_q, issue_d;

    logic              hazard_c;
    logic              sb_empty_c;
    logic              sb_busy_w;
    logic              live;
    logic              fu_legal;
    logic              go;
    logic              dispatch;
    logic              retire_ill;
    logic              retire_halt;
    logic              done;
    logic              set_en;
    logic              in_ready_c;
    logic [NUM_FU-1:0] fu_valid_c;

    issue_scoreboard #(
        .NUM_WB (NUM_WB)
    ) u_sb (
        .CLK      (CLK),
        .nRST     (nRST),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .rs1      (slot_q.rs1),
        .rs2      (slot_q.rs2),
        .rd       (slot_q.rd),
        .src_used (slot_q.src_used),
        .wen      (slot_q.wen),
        .set_en   (set_en),
        .hazard_c (hazard_c),
        .empty_c  (sb_empty_c),
        .busy     (sb_busy_w)
    );

    // Slot decision: dispatch to a lane, or retire illegal/halt once all writes have drained.
    always_comb begin
        live     = (state_q == HOLD) && !flush;
        fu_legal = (32'(slot_q.fu) < NUM_FU);
        go       = live && !hazard_c && (!slot_q.serial || sb_empty_c) &&
                   !slot_q.illegal && !slot_q.halt && fu_legal;
        fu_valid_c = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid_c[i] = go && (32'(slot_q.fu) == 32'(i));
        end
        dispatch    = |(fu_valid_c & fu_ready);
        retire_ill  = live && sb_empty_c && (slot_q.illegal || !fu_legal);
        retire_halt = live && sb_empty_c && slot_q.halt && !slot_q.illegal && fu_legal;
        done        = dispatch || retire_ill || retire_halt;
        set_en      = dispatch && slot_q.wen;
    end

    always_comb begin
        in_slot.rs1      = in_rs1;
        in_slot.rs2      = in_rs2;
        in_slot.rd       = in_rd;
        in_slot.src_used = in_src_used;
        in_slot.wen      = in_wen;
        in_slot.fu       = in_fu;
        in_slot.serial   = in_serial;
        in_slot.halt     = in_halt;
        in_slot.illegal  = in_illegal;
        in_slot.pc       = in_pc;
    end

    // Next-state, slot load and counters.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        in_ready_c  = 1'b0;
        exc_valid_d = retire_ill;
        exc_pc_d    = retire_ill ? slot_q.pc : exc_pc_q;
        stall_d     = stall_q;
        issue_d     = issue_q;

        if (dispatch) begin
            issue_d = issue_q + CNT_W'(1);
        end
        if ((state_q == HOLD) && !done && !flush) begin
            stall_d = stall_q + CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                in_ready_c = !flush;
                if (in_valid && !flush) begin
                    state_d = HOLD;
                    slot_d  = in_slot;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d = EMPTY;
                end else if (retire_halt) begin
                    state_d = HALTED;
                end else if (done) begin
                    // zero-bubble refill when the slot frees this cycle
                    in_ready_c = 1'b1;
                    if (in_valid) begin
                        slot_d = in_slot;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= EMPTY;
            slot_q      <= '0;
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
            stall_q     <= '0;
            issue_q     <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
            stall_q     <= stall_d;
            issue_q     <= issue_d;
        end
    end

    assign in_ready    = in_ready_c;
    assign fu_valid    = fu_valid_c;
    assign out_rs1     = slot_q.rs1;
    assign out_rs2     = slot_q.rs2;
    assign out_rd      = slot_q.rd;
    assign out_pc      = slot_q.pc;
    assign exc_valid   = exc_valid_q;
    assign exc_pc      = exc_pc_q;
    assign halted      = (state_q == HALTED);
    assign sb_busy     = sb_busy_w;
    assign stall_count = stall_q;
    assign issue_count = issue_q;

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Scoreboard bench for issue_dispatch_unit: expected dispatches and exceptions are queued
// when an instruction is driven and compared when the DUT hands them out.
module tb_issue_dispatch_unit;

    localparam int unsigned NUM_FU = 5;
    localparam int unsigned NUM_WB = 2;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic [2:0]  fu;
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic [1:0]        in_src_used;
    logic              in_wen;
    logic [2:0]        in_fu;
    logic              in_serial, in_halt, in_illegal;
    logic [31:0]       in_pc;
    logic [NUM_FU-1:0] fu_valid, fu_ready;
    logic [4:0]        out_rs1, out_rs2, out_rd;
    logic [31:0]       out_pc;
    logic [NUM_WB-1:0] wb_valid;
    logic [5*NUM_WB-1:0] wb_rd;
    logic              flush;
    logic              exc_valid;
    logic [31:0]       exc_pc;
    logic              halted;
    logic              sb_busy;
    logic [CNT_W-1:0]  stall_count, issue_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [31:0] exc_q[$];
    exp_t mon_e;
    logic [31:0] mon_pc;

    issue_dispatch_unit #(.NUM_FU(NUM_FU), .NUM_WB(NUM_WB), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_src_used(in_src_used), .in_wen(in_wen), .in_fu(in_fu),
        .in_serial(in_serial), .in_halt(in_halt), .in_illegal(in_illegal), .in_pc(in_pc),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .halted(halted), .sb_busy(sb_busy),
        .stall_count(stall_count), .issue_count(issue_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pend();
        return dut.u_sb.pend_q;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one instruction and hold it until the slot takes it.
    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [1:0] su, input logic wen, input logic [2:0] fu,
                        input logic serial, input logic halt, input logic illegal,
                        input logic [31:0] pc, input bit exp_disp);
        bit ok = 0;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_src_used = su; in_wen = wen;
        in_fu = fu; in_serial = serial; in_halt = halt; in_illegal = illegal; in_pc = pc;
        in_valid = 1'b1;
        if (exp_disp) exp_q.push_back({fu, rd, pc});
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb1(input logic [4:0] r);
        wb_valid = 2'b01;
        wb_rd    = {5'd0, r};
    endtask

    // Every handshake taken by a lane must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (nRST && ((fu_valid & fu_ready) != '0)) begin
            if (exp_q.size() == 0) begin
                chk("disp_unexpected", 32'(fu_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("disp_lane", 32'(fu_valid), 32'd1 << mon_e.fu);
                chk("disp_rd", 32'(out_rd), 32'(mon_e.rd));
                chk("disp_pc", out_pc, mon_e.pc);
            end
        end
        if (nRST && exc_valid) begin
            if (exc_q.size() == 0) begin
                chk("exc_unexpected", exc_pc, 32'hffff_ffff);
            end else begin
                mon_pc = exc_q.pop_front();
                chk("exc_pc_mon", exc_pc, mon_pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_src_used = '0; in_wen = 1'b0; in_fu = '0; in_serial = 1'b0; in_halt = 1'b0;
        in_illegal = 1'b0; in_pc = '0; fu_ready = '0; wb_valid = '0; wb_rd = '0; flush = 1'b0;

        // reset state
        @(negedge CLK);
        chk("rst_fu_valid", 32'(fu_valid), 32'd0);
        chk("rst_exc", 32'(exc_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(sb_busy), 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        chk("rst_issue", issue_count, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_exc_pc", exc_pc, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        fu_ready = 5'b11111;

        // add x3 on arith lane
        send(5'd1, 5'd2, 5'd3, 2'b11, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h10, 1);
        @(negedge CLK);
        chk("t1_fu_valid", 32'(fu_valid), 32'h1);
        tick();
        @(negedge CLK);
        chk("t1_pend3", 32'(pend()), 32'h8);
        chk("t1_issue", issue_count, 32'd1);
        chk("t1_busy", 32'(sb_busy), 32'd1);
        tick();

        // RAW on x3, resolved by a same-cycle writeback
        send(5'd3, 5'd0, 5'd4, 2'b01, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h14, 1);
        @(negedge CLK);
        chk("t2_hold0", 32'(fu_valid), 32'd0);
        chk("t2_stall0", stall_count, 32'd0);
        tick();
        @(negedge CLK);
        chk("t2_hold1", 32'(fu_valid), 32'd0);
        chk("t2_stall1", stall_count, 32'd1);
        tick();
        wb1(5'd3);
        @(negedge CLK);
        chk("t2_wb_disp", 32'(fu_valid), 32'h2);
        chk("t2_stall2", stall_count, 32'd2);
        tick();
        wb_valid = '0;
        @(negedge CLK);
        chk("t2_pend", pend(), 32'h10);
        chk("t2_issue", issue_count, 32'd2);
        chk("t2_stall_keep", stall_count, 32'd2);
        tick();

        // WAW on x5 with set/clear collision on the same cycle
        send(5'd0, 5'd0, 5'd5, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h18, 1);
        @(negedge CLK);
        chk("t3_disp_a", 32'(fu_valid), 32'h1);
        tick();
        send(5'd0, 5'd0, 5'd5, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h1c, 1);
        @(negedge CLK);
        chk("t3_waw_hold", 32'(fu_valid), 32'd0);
        tick();
        wb1(5'd5);
        @(negedge CLK);
        chk("t3_disp_b", 32'(fu_valid), 32'h1);
        tick();
        wb_valid = '0;
        @(negedge CLK);
        chk("t3_pend5_kept", 32'(pend()), 32'h30);
        chk("t3_stall", stall_count, 32'd3);
        chk("t3_issue", issue_count, 32'd4);
        tick();
        wb_valid = 2'b11;
        wb_rd    = {5'd5, 5'd4};
        tick();
        wb_valid = '0;
        @(negedge CLK);
        chk("t3_busy_clr", 32'(sb_busy), 32'd0);
        tick();

        // serialising CSR waits for an empty scoreboard; rd=x0 never sets pend
        send(5'd0, 5'd0, 5'd7, 2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h20, 1);
        @(negedge CLK);
        chk("t4_div", 32'(fu_valid), 32'h4);
        tick();
        send(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 32'h24, 1);
        @(negedge CLK);
        chk("t4_csr_hold0", 32'(fu_valid), 32'd0);
        tick();
        @(negedge CLK);
        chk("t4_csr_hold1", 32'(fu_valid), 32'd0);
        tick();
        wb1(5'd7);
        @(negedge CLK);
        chk("t4_csr_disp", 32'(fu_valid), 32'h10);
        tick();
        wb_valid = '0;
        @(negedge CLK);
        chk("t4_pend_x0", pend(), 32'd0);
        chk("t4_busy", 32'(sb_busy), 32'd0);
        chk("t4_issue", issue_count, 32'd6);
        chk("t4_stall", stall_count, 32'd5);
        tick();

        // illegal lane encoding and illegal flag
        exc_q.push_back(32'h100);
        send(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 32'h100, 0);
        @(negedge CLK);
        chk("t5_no_fu", 32'(fu_valid), 32'd0);
        chk("t5_no_exc_yet", 32'(exc_valid), 32'd0);
        tick();
        @(negedge CLK);
        chk("t5_exc", 32'(exc_valid), 32'd1);
        chk("t5_exc_pc", exc_pc, 32'h100);
        chk("t5_empty", 32'(in_ready), 32'd1);
        tick();
        @(negedge CLK);
        chk("t5_exc_pulse", 32'(exc_valid), 32'd0);
        chk("t5_issue", issue_count, 32'd6);
        tick();
        exc_q.push_back(32'h104);
        send(5'd0, 5'd0, 5'd9, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h104, 0);
        @(negedge CLK);
        chk("t5b_no_fu", 32'(fu_valid), 32'd0);
        tick();
        @(negedge CLK);
        chk("t5b_exc", 32'(exc_valid), 32'd1);
        chk("t5b_no_pend", pend(), 32'd0);
        tick();

        // flush with lane not ready: slot drops, scoreboard survives
        send(5'd0, 5'd0, 5'd10, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h30, 1);
        @(negedge CLK);
        chk("t6_disp", 32'(fu_valid), 32'h1);
        tick();
        fu_ready = '0;
        send(5'd0, 5'd0, 5'd11, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h34, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_pc = 32'h38;
        @(negedge CLK);
        chk("t6_flush_ready", 32'(in_ready), 32'd0);
        chk("t6_flush_fu", 32'(fu_valid), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("t6_empty_fu", 32'(fu_valid), 32'd0);
        chk("t6_pend", pend(), 32'h400);
        chk("t6_stall", stall_count, 32'd5);
        chk("t6_issue", issue_count, 32'd7);
        tick();
        fu_ready = 5'b11111;
        wb1(5'd10);
        tick();
        wb_valid = '0;

        // reset while an instruction sits in the slot
        fu_ready = '0;
        send(5'd0, 5'd0, 5'd12, 2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40, 0);
        nRST = 1'b0;
        @(negedge CLK);
        chk("t7_fu", 32'(fu_valid), 32'd0);
        chk("t7_issue", issue_count, 32'd0);
        chk("t7_stall", stall_count, 32'd0);
        chk("t7_busy", 32'(sb_busy), 32'd0);
        chk("t7_out_pc", out_pc, 32'd0);
        chk("t7_out_rd", 32'(out_rd), 32'd0);
        chk("t7_exc", 32'(exc_valid), 32'd0);
        chk("t7_halted", 32'(halted), 32'd0);
        tick();
        nRST = 1'b1;
        fu_ready = 5'b11111;

        // halt: retires, then only reset leaves HALTED
        send(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h50, 0);
        @(negedge CLK);
        chk("t8_no_fu", 32'(fu_valid), 32'd0);
        tick();
        @(negedge CLK);
        chk("t8_halted", 32'(halted), 32'd1);
        chk("t8_ready", 32'(in_ready), 32'd0);
        chk("t8_issue", issue_count, 32'd0);
        tick();
        flush = 1'b1;
        in_valid = 1'b1;
        in_halt = 1'b0;
        in_pc = 32'h60;
        tick();
        @(negedge CLK);
        chk("t8_flush_halted", 32'(halted), 32'd1);
        chk("t8_flush_ready", 32'(in_ready), 32'd0);
        chk("t8_flush_fu", 32'(fu_valid), 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;

        chk("disp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
